alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL match the 16-bit datapath ALU.
REQ-002 CLK  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset.
REQ-004 ReqValid  input  1  request present.
REQ-005 ReqReady  output  1  block accepts a request this cycle.
REQ-006 Op  input  3  operation: 0 AND, 1 OR, 2 ADD, 3 SUB (A-B), 4 RSUB (B-A), 5 SLT (A<B unsigned), 6 ABSDIFF (|A-B|), 7 MAX (unsigned).
REQ-007 OpA, OpB  input  WIDTH  request operands.
REQ-008 AluCtl  output  3  ALU control code: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT.
REQ-009 AluA, AluB  output  WIDTH  ALU operands.
REQ-010 AluFlip  output  1  ALU operand-swap select (SUB/SLT compute B-A, B<A when 1).
REQ-011 AluOut  input  WIDTH  combinational ALU result for current AluCtl/AluA/AluB/AluFlip.
REQ-012 AluZero  input  1  AluOut == 0.
REQ-013 RspValid  output  1  Result valid.
REQ-014 RspReady  input  1  consumer takes response.
REQ-015 Result  output  WIDTH  final result register.
REQ-016 ResultZero  output  1  registered AluZero of final pass.
REQ-017 Busy  output  1  state != IDLE.

Function
REQ-018 FSM states IDLE, EXEC1, EXEC2, DONE; ReqReady SHALL be 1 only in IDLE with Reset high.
REQ-019 IDLE: on ReqValid&&ReqReady SHALL register Op, OpA, OpB and go EXEC1; otherwise stay.
REQ-020 EXEC1 ALU drive from registered values: AND ctl0; OR ctl1; ADD ctl2; SUB ctl6 Flip0; RSUB ctl6 Flip1; SLT, ABSDIFF, MAX ctl7 Flip0; AluA=A, AluB=B in all cases.
REQ-021 EXEC1, Op 0-5: SHALL capture AluOut->Result, AluZero->ResultZero, go DONE.
REQ-022 EXEC1, Op 6-7: SHALL capture AluOut[0] into internal flag lt, go EXEC2; Result unchanged.
REQ-023 EXEC2 ABSDIFF: ctl6, AluA=A, AluB=B, AluFlip=lt; MAX: ctl1, AluA=(lt ? B : A), AluB=0, Flip0; SHALL capture AluOut/AluZero, go DONE.
REQ-024 Outside EXEC1/EXEC2, AluCtl, AluA, AluB, AluFlip SHALL be 0.
REQ-025 DONE: RspValid=1, Result/ResultZero held stable; on RspReady go IDLE; ReqValid ignored in DONE.
REQ-026 Latency: request accepted at edge k -> RspValid high after edge k+1 (Op 0-5) or k+2 (Op 6-7); next accept no earlier than the edge after the RspReady handshake.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH; comparisons unsigned; no overflow flag.
REQ-028 Registered operands SHALL not change between accept and DONE exit regardless of OpA/OpB/Op inputs.
REQ-029 Op values outside 0-7 cannot occur (3-bit); no illegal-state recovery beyond default->IDLE.

Reset
REQ-030 Reset low at an edge SHALL force IDLE, Result=0, ResultZero=0, lt=0, RspValid=0, Busy=0, from any state including EXEC1/EXEC2/DONE; in-flight request discarded, no response.
REQ-031 While Reset low, ReqReady SHALL be 0 and ALU drive outputs 0.

Verification
REQ-032 ADD A=0x0003 B=0x0004 -> EXEC1 AluCtl=2; Result=0x0007, ResultZero=0, RspValid after edge k+1.
REQ-033 SUB A=0x0005 B=0x0005 -> AluCtl=6 Flip0; Result=0x0000, ResultZero=1; RSUB A=0x0002 B=0x0009 -> Flip1, Result=0x0007.
REQ-034 ABSDIFF A=0x0003 B=0x000A -> EXEC1 ctl7 AluOut=1; EXEC2 ctl6 Flip1; Result=0x0007, RspValid after edge k+2; swapped operands also give 0x0007 with Flip0.
REQ-035 MAX A=0x8000 B=0x0001 -> lt=0, EXEC2 ctl1 AluA=0x8000 AluB=0; Result=0x8000 (unsigned).
REQ-036 RspReady held 0 for 5 cycles in DONE with ReqValid=1 and changing OpA -> Result stable, ReqReady=0, no accept; RspReady=1 -> IDLE next edge, ReqReady=1.
REQ-037 Reset low during EXEC2 of ABSDIFF -> next edge IDLE, Result=0, RspValid never asserted for that request.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for an external combinational 16-bit ALU: accepts one request,
// drives the ALU for one or two passes, then holds the registered result until it is taken.
module alu_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic [2:0]       AluCtl,
   output logic [WIDTH-1:0] AluA,
   output logic [WIDTH-1:0] AluB,
   output logic             AluFlip,
   input  logic [WIDTH-1:0] AluOut,
   input  logic             AluZero,
   output logic             RspValid,
   input  logic             RspReady,
   output logic [WIDTH-1:0] Result,
   output logic             ResultZero,
   output logic             Busy,
   output logic [1:0]       DbgState
);

   // Handshakes: a request transfers on a rising edge where ReqValid && ReqReady; a response
   // transfers on a rising edge where RspValid && RspReady. Neither valid depends on its ready.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC1 = 2'd1,
      EXEC2 = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [2:0] CTL_AND = 3'd0;
   localparam logic [2:0] CTL_OR  = 3'd1;
   localparam logic [2:0] CTL_ADD = 3'd2;
   localparam logic [2:0] CTL_SUB = 3'd6;
   localparam logic [2:0] CTL_SLT = 3'd7;

   localparam logic [2:0] OP_AND     = 3'd0;
   localparam logic [2:0] OP_OR      = 3'd1;
   localparam logic [2:0] OP_ADD     = 3'd2;
   localparam logic [2:0] OP_SUB     = 3'd3;
   localparam logic [2:0] OP_RSUB    = 3'd4;
   localparam logic [2:0] OP_ABSDIFF = 3'd6;

   state_t           state;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             lt;

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state      <= IDLE;
         op_r       <= '0;
         a_r        <= '0;
         b_r        <= '0;
         lt         <= 1'b0;
         Result     <= '0;
         ResultZero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ReqValid) begin
                  op_r  <= Op;
                  a_r   <= OpA;
                  b_r   <= OpB;
                  state <= EXEC1;
               end
            end
            EXEC1: begin
               // ABSDIFF and MAX need the A<B comparison before the final pass
               if (op_r >= OP_ABSDIFF) begin
                  lt    <= AluOut[0];
                  state <= EXEC2;
               end else begin
                  Result     <= AluOut;
                  ResultZero <= AluZero;
                  state      <= DONE;
               end
            end
            EXEC2: begin
               Result     <= AluOut;
               ResultZero <= AluZero;
               state      <= DONE;
            end
            DONE: begin
               if (RspReady) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      AluCtl  = CTL_AND;
      AluA    = '0;
      AluB    = '0;
      AluFlip = 1'b0;
      if (Reset) begin
         case (state)
            EXEC1: begin
               AluA = a_r;
               AluB = b_r;
               case (op_r)
                  OP_AND:  AluCtl = CTL_AND;
                  OP_OR:   AluCtl = CTL_OR;
                  OP_ADD:  AluCtl = CTL_ADD;
                  OP_SUB:  AluCtl = CTL_SUB;
                  OP_RSUB: begin
                     AluCtl  = CTL_SUB;
                     AluFlip = 1'b1;
                  end
                  default: AluCtl = CTL_SLT;
               endcase
            end
            EXEC2: begin
               if (op_r == OP_ABSDIFF) begin
                  AluCtl  = CTL_SUB;
                  AluA    = a_r;
                  AluB    = b_r;
                  AluFlip = lt;
               end else begin
                  // MAX: pass the larger operand through OR with zero
                  AluCtl = CTL_OR;
                  AluA   = lt ? b_r : a_r;
               end
            end
            default: ;
         endcase
      end
   end

   assign ReqReady = Reset && (state == IDLE);
   assign RspValid = (state == DONE);
   assign Busy     = (state != IDLE);
   assign DbgState = state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU on the ALU port, directed and random requests,
// expected responses queued at issue and compared by an independent response monitor.
module tb_alu_seq_ctrl;

   localparam int W = 16;

   logic         CLK = 1'b0;
   logic         Reset;
   logic         ReqValid;
   logic         ReqReady;
   logic [2:0]   Op;
   logic [W-1:0] OpA;
   logic [W-1:0] OpB;
   logic [2:0]   AluCtl;
   logic [W-1:0] AluA;
   logic [W-1:0] AluB;
   logic         AluFlip;
   logic [W-1:0] AluOut;
   logic         AluZero;
   logic         RspValid;
   logic         RspReady;
   logic [W-1:0] Result;
   logic         ResultZero;
   logic         Busy;
   logic [1:0]   DbgState;

   int total  = 0;
   int passed = 0;
   logic [W:0] exp_q[$];

   alu_seq_ctrl #(.WIDTH(W)) dut (
      .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .Op(Op),
      .OpA(OpA), .OpB(OpB), .AluCtl(AluCtl), .AluA(AluA), .AluB(AluB), .AluFlip(AluFlip),
      .AluOut(AluOut), .AluZero(AluZero), .RspValid(RspValid), .RspReady(RspReady),
      .Result(Result), .ResultZero(ResultZero), .Busy(Busy), .DbgState(DbgState)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   // the external datapath ALU
   always_comb begin
      AluOut = '0;
      case (AluCtl)
         3'd0: AluOut = AluA & AluB;
         3'd1: AluOut = AluA | AluB;
         3'd2: AluOut = AluA + AluB;
         3'd6: AluOut = AluFlip ? (AluB - AluA) : (AluA - AluB);
         3'd7: AluOut = {{(W-1){1'b0}}, AluFlip ? (AluB < AluA) : (AluA < AluB)};
         default: AluOut = '0;
      endcase
      AluZero = (AluOut == '0);
   end

   // reference model: what each operation means
   function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a + b;
         3'd3: return a - b;
         3'd4: return b - a;
         3'd5: return (a < b) ? 1 : 0;
         3'd6: return (a >= b) ? a - b : b - a;
         default: return (a >= b) ? a : b;
      endcase
   endfunction

   function automatic logic [2:0] ref_ctl(input logic [2:0] op);
      case (op)
         3'd0: return 3'd0;
         3'd1: return 3'd1;
         3'd2: return 3'd2;
         3'd3, 3'd4: return 3'd6;
         default: return 3'd7;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // scoreboard monitor
   always @(negedge CLK) begin
      if (RspValid && RspReady) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL rsp_unexpected: got result 0x%0h expected no response", Result);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            if ({ResultZero, Result} === e) passed++;
            else $display("FAIL rsp: got zero=%0b result=0x%0h expected zero=%0b result=0x%0h",
                          ResultZero, Result, e[W], e[W-1:0]);
         end
      end
   end

   // driver: issue one request, check ALU drive and latency, hold response for `hold` cycles
   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold);
      int cyc;
      logic [W-1:0] r, held;
      r = ref_result(op, a, b);
      @(negedge CLK);
      cyc = 0;
      while (!ReqReady && cyc < 50) begin
         @(negedge CLK);
         cyc++;
      end
      if (!ReqReady) begin
         check("req_ready_timeout", 32'(ReqReady), 32'd1);
         return;
      end
      ReqValid = 1'b1; Op = op; OpA = a; OpB = b;
      exp_q.push_back({(r == '0), r});
      @(posedge CLK); #1;
      ReqValid = 1'b0; Op = 3'($urandom); OpA = W'($urandom); OpB = W'($urandom);
      check("exec1_ctl", 32'(AluCtl), 32'(ref_ctl(op)));
      check("exec1_flip", 32'(AluFlip), 32'(op == 3'd4));
      check("exec1_ab", {AluA, AluB}, {a, b});
      if (op >= 3'd6) begin
         check("rsp_early", 32'(RspValid), 32'd0);
         @(posedge CLK); #1;
         if (op == 3'd6) begin
            check("exec2_ctl", 32'(AluCtl), 32'd6);
            check("exec2_flip", 32'(AluFlip), 32'(a < b));
            check("exec2_ab", {AluA, AluB}, {a, b});
         end else begin
            check("exec2_ctl", 32'(AluCtl), 32'd1);
            check("exec2_ab", {AluA, AluB}, {((a < b) ? b : a), {W{1'b0}}});
         end
      end
      @(posedge CLK); #1;
      check("rsp_latency", 32'(RspValid), 32'd1);
      held = Result;
      for (int i = 0; i < hold; i++) begin
         ReqValid = 1'b1; Op = 3'($urandom); OpA = W'($urandom); OpB = W'($urandom);
         @(posedge CLK); #1;
         check("done_hold", {15'd0, ReqReady, Result}, {15'd0, 1'b0, held});
      end
      RspReady = 1'b1;
      @(posedge CLK); #1;
      RspReady = 1'b0; ReqValid = 1'b0;
      check("back_idle", {30'd0, RspValid, ReqReady}, {30'd0, 1'b0, 1'b1});
   endtask

   initial begin
      Reset = 1'b0; ReqValid = 1'b0; RspReady = 1'b0; Op = '0; OpA = '0; OpB = '0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_state", {27'd0, ReqReady, Busy, RspValid, ResultZero, AluFlip},
            32'd0);
      check("reset_result", {13'd0, AluCtl, Result}, 32'd0);
      Reset = 1'b1;
      #1;
      check("reset_release_ready", 32'(ReqReady), 32'd1);

      send(3'd2, 16'h0003, 16'h0004, 0);
      send(3'd3, 16'h0005, 16'h0005, 1);
      send(3'd4, 16'h0002, 16'h0009, 0);
      send(3'd6, 16'h0003, 16'h000A, 0);
      send(3'd6, 16'h000A, 16'h0003, 0);
      send(3'd7, 16'h8000, 16'h0001, 5);
      send(3'd5, 16'hFFFF, 16'h0000, 0);
      send(3'd2, 16'hFFFF, 16'h0001, 0);

      // reset during EXEC2 of an ABSDIFF: the request must vanish
      @(negedge CLK);
      ReqValid = 1'b1; Op = 3'd6; OpA = 16'h0003; OpB = 16'h000A;
      @(posedge CLK); #1;
      ReqValid = 1'b0;
      @(posedge CLK); #1;
      check("abort_busy", 32'(Busy), 32'd1);
      Reset = 1'b0;
      @(posedge CLK); #1;
      check("abort_state", {27'd0, Busy, RspValid, ReqReady, ResultZero, AluFlip}, 32'd0);
      check("abort_result", {13'd0, AluCtl, Result}, 32'd0);
      Reset = 1'b1; RspReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         check("abort_no_rsp", 32'(RspValid), 32'd0);
      end
      RspReady = 1'b0;

      for (int n = 0; n < 40; n++) begin
         logic [W-1:0] a, b;
         a = W'($urandom);
         b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
         send(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 3));
      end

      repeat (3) @(posedge CLK);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
